// File: rtl/btn_op_selector_if.sv
// btn_op_selector_if: raw button inputs and op-select outputs between a button panel and the selector
interface btn_op_selector_if #(
    parameter int OP_W = 3
);
    logic btn_up;
    logic btn_down;
    logic [OP_W-1:0] op_sel;
    logic up_pulse;
    logic down_pulse;
    logic op_changed;
    modport master (
        output btn_up, btn_down,
        input  op_sel, up_pulse, down_pulse, op_changed
    );
    modport slave (
        input  btn_up, btn_down,
        output op_sel, up_pulse, down_pulse, op_changed
    );
endinterface

// File: rtl/btn_op_selector.sv
// btn_op_selector: synchronizes and debounces up/down buttons, steering a saturating or wrapping op select
module btn_op_selector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OP_W = 3,
    parameter int RESET_OP = 0,
    parameter int WRAP = 0
) (
    input logic clk,
    input logic rst,
    btn_op_selector_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [OP_W-1:0] OP_MAX = '1;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stable;
    logic [1:0] rise;
    logic [CW-1:0] cnt [2];
    logic up_only;
    logic down_only;
    logic [OP_W-1:0] op_nxt;
    // Bit 0 is the up button, bit 1 the down button; rise marks an accepted 0->1 press.
    always_comb begin
        rise = '0;
        for (int i = 0; i < 2; i++)
            rise[i] = sync2[i] && !stable[i] && cnt[i] == CNT_LAST;
        up_only = rise[0] && !rise[1];
        down_only = rise[1] && !rise[0];
        op_nxt = up_only ? ((bus.op_sel == OP_MAX && WRAP == 0) ? bus.op_sel : bus.op_sel + 1'b1) :
                 down_only ? ((bus.op_sel == '0 && WRAP == 0) ? bus.op_sel : bus.op_sel - 1'b1) :
                 bus.op_sel;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            stable <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
            bus.op_sel <= OP_W'(RESET_OP);
            bus.up_pulse <= 1'b0;
            bus.down_pulse <= 1'b0;
            bus.op_changed <= 1'b0;
        end else begin
            sync1 <= {bus.btn_down, bus.btn_up};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= (sync2[i] == stable[i] || cnt[i] == CNT_LAST) ? '0 : cnt[i] + 1'b1;
                if (sync2[i] != stable[i] && cnt[i] == CNT_LAST)
                    stable[i] <= sync2[i];
            end
            bus.up_pulse <= rise[0];
            bus.down_pulse <= rise[1];
            bus.op_sel <= op_nxt;
            bus.op_changed <= op_nxt != bus.op_sel;
        end
    end
endmodule

// File: tb/tb_btn_op_selector.sv
// tb_btn_op_selector: two configurations driven by shared random/directed button stimulus, scoreboarded
module tb_btn_op_selector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    btn_op_selector_if #(.OP_W(3)) b0 ();
    btn_op_selector_if #(.OP_W(3)) b1 ();
    btn_op_selector #(.DEBOUNCE_CYCLES(4), .OP_W(3), .RESET_OP(0), .WRAP(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );
    btn_op_selector #(.DEBOUNCE_CYCLES(1), .OP_W(3), .RESET_OP(5), .WRAP(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    int dc [2] = '{4, 1};
    int ro [2] = '{0, 5};
    int wr [2] = '{0, 1};
    logic [1:0] rq [2];
    logic [7:0] hist [2];
    int nv = 0;
    logic st [2][2];
    int op [2];
    logic [11:0] sbq [$];
    logic [11:0] m;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    // Reference: a press is accepted once the last D synchronized samples all disagree with the stable level.
    task automatic model_edge();
        logic [11:0] e;
        logic raw [2];
        logic acc [2];
        int nop;
        raw[0] = b0.btn_up;
        raw[1] = b0.btn_down;
        if (rst) begin
            nv = 0;
            for (int b = 0; b < 2; b++) begin
                rq[b] = '0;
                hist[b] = '0;
            end
            for (int c = 0; c < 2; c++) begin
                st[c][0] = 1'b0;
                st[c][1] = 1'b0;
                op[c] = ro[c];
                e[c*6 +: 6] = {3'(ro[c]), 3'b000};
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                hist[b] = {hist[b][6:0], rq[b][1]};
                rq[b] = {rq[b][0], raw[b]};
            end
            if (nv < 8) nv++;
            for (int c = 0; c < 2; c++) begin
                for (int b = 0; b < 2; b++) begin
                    acc[b] = nv >= dc[c];
                    for (int i = 0; i < dc[c]; i++)
                        if (hist[b][i] == st[c][b]) acc[b] = 1'b0;
                    if (acc[b]) st[c][b] = !st[c][b];
                    acc[b] = acc[b] && st[c][b];
                end
                nop = op[c];
                if (acc[0] && !acc[1])
                    nop = wr[c] != 0 ? (op[c] + 1) % 8 : (op[c] == 7 ? 7 : op[c] + 1);
                else if (acc[1] && !acc[0])
                    nop = wr[c] != 0 ? (op[c] + 7) % 8 : (op[c] == 0 ? 0 : op[c] - 1);
                e[c*6 +: 6] = {3'(nop), acc[0], acc[1], nop != op[c]};
                op[c] = nop;
            end
        end
        sbq.push_back(e);
    endtask
    task automatic seg(input logic r, input logic u, input logic d, input int n);
        rst = r;
        b0.btn_up = u;
        b0.btn_down = d;
        b1.btn_up = u;
        b1.btn_down = d;
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask
    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got op=%0d up=%b dn=%b chg=%b, expected op=%0d up=%b dn=%b chg=%b",
                     name, cyc, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask
    initial forever begin
        @(negedge clk);
        cyc++;
        if (sbq.size() > 0) begin
            m = sbq.pop_front();
            check("cfg0", {b0.op_sel, b0.up_pulse, b0.down_pulse, b0.op_changed}, m[5:0]);
            check("cfg1", {b1.op_sel, b1.up_pulse, b1.down_pulse, b1.op_changed}, m[11:6]);
        end
    end
    initial begin
        seg(1, 0, 0, 2);
        seg(0, 1, 0, 20);
        seg(0, 0, 0, 10);
        repeat (4) begin
            seg(0, 1, 0, 3);
            seg(0, 0, 0, 3);
        end
        seg(1, 0, 0, 2);
        repeat (9) begin
            seg(0, 1, 0, 8);
            seg(0, 0, 0, 8);
        end
        seg(0, 1, 1, 10);
        seg(0, 0, 0, 8);
        seg(1, 0, 0, 2);
        seg(0, 0, 1, 10);
        seg(0, 0, 0, 8);
        seg(0, 1, 1, 10);
        seg(0, 0, 0, 8);
        seg(0, 1, 0, 3);
        seg(1, 1, 0, 1);
        seg(0, 1, 0, 15);
        seg(0, 0, 0, 8);
        repeat (400) begin
            if ($urandom_range(0, 39) == 0)
                seg(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 2));
            else
                seg(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        seg(0, 0, 0, 4);
        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
